// File: rtl/id_decode_stage.sv
// Registered RV64I decode stage: turns a fetched instruction into an ALU op/operand bundle
// with writeback and branch control. Define ID_RV64_WORD_OPS_EN to decode OP-32/OP-IMM-32 and add out_word.
module id_decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_aluop,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_is_branch,
  output logic [2:0]      out_br_funct3,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
`ifdef ID_RV64_WORD_OPS_EN
  ,
  output logic            out_word
`endif
);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
`ifdef ID_RV64_WORD_OPS_EN
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
`endif

  // aluop[3:2] picks the unit (arith, logic, shift, compare).
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1110;

  typedef struct packed {
    logic [3:0]      aluop;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_branch;
    logic [2:0]      br_funct3;
    logic            illegal;
    logic [XLEN-1:0] pc;
`ifdef ID_RV64_WORD_OPS_EN
    logic            word;
`endif
  } bundle_t;

  // funct3 -> aluop for register and immediate ALU forms; alt selects SUB/SRA.
  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt_ext;
  logic            accept;
  logic            legal;
  logic            writes_rd;
  bundle_t         dec;
  bundle_t         bundle_q;

  assign opcode    = in_inst[6:0];
  assign funct3    = in_inst[14:12];
  assign funct7    = in_inst[31:25];
  assign imm_i     = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_u     = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  assign shamt_ext = {{(XLEN-6){1'b0}}, in_inst[25:20]};

  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    dec       = '0;
    dec.rd    = in_inst[11:7];
    dec.pc    = in_pc;
    legal     = 1'b0;
    writes_rd = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec.op1   = rs1_data;
        dec.op2   = rs2_data;
        dec.aluop = alu_of_f3(funct3, funct7[5]);
        writes_rd = 1'b1;
        legal     = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        dec.op1   = rs1_data;
        writes_rd = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.op2   = shamt_ext;
          dec.aluop = alu_of_f3(funct3, in_inst[30]);
          legal     = (in_inst[31:26] == 6'b000000) ||
                      (in_inst[31:26] == 6'b010000 && funct3 == 3'b101);
        end else begin
          // SLTI/SLTIU/XORI/ORI/ANDI/ADDI carry no funct7, so inst[30] is immediate data.
          dec.op2   = imm_i;
          dec.aluop = alu_of_f3(funct3, 1'b0);
          legal     = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.op2   = imm_u;
        dec.aluop = ALU_ADD;
        writes_rd = 1'b1;
        legal     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1   = in_pc;
        dec.op2   = imm_u;
        dec.aluop = ALU_ADD;
        writes_rd = 1'b1;
        legal     = 1'b1;
      end
      OPC_BRANCH: begin
        dec.op1       = rs1_data;
        dec.op2       = rs2_data;
        dec.is_branch = 1'b1;
        dec.br_funct3 = funct3;
        dec.aluop     = (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SLT;
        legal         = (funct3[2:1] != 2'b01);
      end
`ifdef ID_RV64_WORD_OPS_EN
      OPC_OP_IMM_32: begin
        dec.op1   = rs1_data;
        dec.word  = 1'b1;
        writes_rd = 1'b1;
        if (funct3 == 3'b000) begin
          dec.op2   = imm_i;
          dec.aluop = ALU_ADD;
          legal     = 1'b1;
        end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // The whole funct7 is checked, which also rejects a 6-bit shamt (inst[25]=1).
          dec.op2   = shamt_ext;
          dec.aluop = alu_of_f3(funct3, in_inst[30]);
          legal     = (funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && funct3 == 3'b101);
        end
      end
      OPC_OP_32: begin
        dec.op1   = rs1_data;
        dec.op2   = rs2_data;
        dec.word  = 1'b1;
        dec.aluop = alu_of_f3(funct3, funct7[5]);
        writes_rd = 1'b1;
        legal     = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101) &&
                    ((funct7 == 7'b0000000) ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
`endif
      default: legal = 1'b0;
    endcase

    // Illegal encodings still produce a valid bundle, with the control fields zeroed.
    if (!legal) begin
      dec.aluop     = ALU_ADD;
      dec.op1       = '0;
      dec.op2       = '0;
      dec.is_branch = 1'b0;
      dec.br_funct3 = 3'b000;
`ifdef ID_RV64_WORD_OPS_EN
      dec.word      = 1'b0;
`endif
    end
    dec.illegal = !legal;
    dec.rd_we   = legal && writes_rd && (in_inst[11:7] != 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept && !flush) bundle_q <= dec;
    end
  end

  assign out_aluop     = bundle_q.aluop;
  assign out_op1       = bundle_q.op1;
  assign out_op2       = bundle_q.op2;
  assign out_rd        = bundle_q.rd;
  assign out_rd_we     = bundle_q.rd_we;
  assign out_is_branch = bundle_q.is_branch;
  assign out_br_funct3 = bundle_q.br_funct3;
  assign out_illegal   = bundle_q.illegal;
  assign out_pc        = bundle_q.pc;
`ifdef ID_RV64_WORD_OPS_EN
  assign out_word      = bundle_q.word;
`endif

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered RV64I decode stage. It produces the `aluop`/`op1`/`op2` bundle that the execute-stage ALU consumes, plus writeback and branch control.
- Accepts a fetched instruction and PC over a valid/ready handshake and drives register-file read addresses combinationally.
- Latches the decoded operands into a single output register that holds under backpressure and clears on flush.
- Sits between fetch and execute.

Parameters:
- XLEN, 64, datapath width of operands and PC.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; asynchronous, active-high
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rs1_addr  out  5  regfile read address, equal to in_inst[19:15]
- rs2_addr  out  5  regfile read address, equal to in_inst[24:20]
- rs1_data  in  XLEN  regfile read data, same cycle
- rs2_data  in  XLEN  regfile read data, same cycle
- flush  in  1  kill the held instruction and any incoming one
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_aluop  out  4  ALU operation code
- out_op1  out  XLEN  ALU operand 1
- out_op2  out  XLEN  ALU operand 2
- out_rd  out  5  destination register
- out_rd_we  out  1  writeback enable
- out_is_branch  out  1  conditional branch
- out_br_funct3  out  3  branch condition (funct3)
- out_illegal  out  1  unsupported or illegal encoding
- out_pc  out  XLEN  PC of the bundle

Behaviour:
- Reset: every output register is 0, including out_valid. The reset is asynchronous and takes effect mid-transfer.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready; the decoded bundle is registered on that clk edge.
  - Latency is 1 cycle.
  - If out_valid && !out_ready, all out_* hold stable.
  - If neither an accept nor a drain occurs, out_valid is unchanged.
  - If out_ready is high and there is no accept, out_valid goes to 0 on the next edge.
- Flush has priority. On the next edge out_valid=0. An instruction accepted in the same cycle is discarded. Data fields are don't-care while out_valid=0.
- aluop encoding:
  - [3:2] selects the unit: 00 arith, 01 logic, 10 shift, 11 compare.
  - ADD 0000, SUB 0001.
  - XOR 0100, OR 0110, AND 0111.
  - SLL 1000, SRL 1001, SRA 1011.
  - SLT 1100, SLTU 1110.
- Decode rules:
  - OP (0110011): op1=rs1_data, op2=rs2_data. funct7 must be 0000000, or 0100000 only for SUB/SRA.
  - OP-IMM (0010011): op1=rs1_data, op2=sign-extended imm[11:0].
    - Shifts use op2 = zero-extended shamt[5:0]; inst[30] selects SRAI.
    - inst[31:26] must be 000000 or 010000 (010000 only for SRAI).
  - LUI: op1=0, op2=sext({inst[31:12],12'b0}), aluop ADD.
  - AUIPC: op1=in_pc, op2 as for LUI, aluop ADD.
  - BRANCH (1100011): op1=rs1_data, op2=rs2_data, out_is_branch=1, out_br_funct3=funct3, rd_we=0.
    - aluop is 1100 for funct3 000/001/100/101 and 1110 for 110/111.
    - funct3 010/011 is illegal.
- out_rd = inst[11:7]. out_rd_we=1 for OP/OP-IMM/LUI/AUIPC only when rd != 0.
- Any other opcode, or a bad funct field: out_illegal=1, aluop=0000, rd_we=0, is_branch=0, op1/op2=0. The bundle is still valid.
- Arithmetic: all sign extension is to XLEN, and immediates are computed from in_inst only.

Optional Feature:
- Macro: ID_RV64_WORD_OPS_EN.
- With the macro defined:
  - An extra output `out_word` (1 bit) is added.
  - OP-IMM-32 (0011011: ADDIW/SLLIW/SRLIW/SRAIW) and OP-32 (0111011: ADDW/SUBW/SLLW/SRLW/SRAW) decode with the same aluop mapping and out_word=1.
  - A W-shift with inst[25]=1 is illegal.
- Without the macro: the port is absent, and those opcodes decode as illegal.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1_data=10, out_ready=1 -> next cycle: out_valid=1, aluop=0000, op1=10, op2=0xFFFFFFFFFFFFFFFF, rd=5, rd_we=1.
- SRAI x3,x2,63 (0x43F15193) -> aluop=1011, op2=63, rd=3, illegal=0.
- BLTU x1,x2 (0x0020E063) -> aluop=1110, is_branch=1, br_funct3=6, rd_we=0, rs1_addr=1, rs2_addr=2.
- Backpressure: accept ADD, hold out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and out_* stable; out_ready=1 -> ADD drains and the next instruction is accepted on the same edge.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0. Both instructions are lost.
- in_inst=0x00000000 -> out_illegal=1, rd_we=0. ADDIW (0x0010809B) -> illegal without the macro; with ID_RV64_WORD_OPS_EN: out_word=1, aluop=0000, op2=1.
